stopwatch_ctrl: RTL and testbench

//  Upstream control stage for the 4-digit stopwatch counter/display. Synchronises and debounces raw

---
 rtl/stopwatch_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: button sync/debounce, run FSM, 1 ms prescaler.
// Optional lap/hold feature is compiled in when LAP_HOLD_EN is defined.
module stopwatch_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
`ifdef LAP_HOLD_EN
    input  logic       btn_lap,
    output logic       hold,
`endif
    output logic       run,
    output logic [1:0] state,
    output logic       tick_ms,
    output logic       count_en,
    output logic       clear_pulse
);

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLEAR = 2;
`ifdef LAP_HOLD_EN
    localparam int B_LAP   = 3;
    localparam int NB      = 4;
`else
    localparam int NB      = 3;
`endif

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] press;

`ifdef LAP_HOLD_EN
    assign raw = {btn_lap, btn_clear, btn_stop, btn_start};
`else
    assign raw = {btn_clear, btn_stop, btn_start};
`endif

    for (genvar b = 0; b < NB; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   level_q;
        logic                   level_prev_q;
        logic                   sync_out;

        assign sync_out = sync_q[SYNC_STAGES-1];

        // Plain flop chain bringing the raw button into the clock domain
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[b]};
            end
        end

        // Accept a new level only after it has been stable long enough
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (sync_out == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // Delayed copy of the accepted level for rising-edge detection
        always_ff @(posedge clk) begin
            if (reset) begin
                level_prev_q <= 1'b0;
            end else begin
                level_prev_q <= level_q;
            end
        end

        assign press[b] = level_q & ~level_prev_q;
    end

    state_t state_q;
    state_t state_d;
    logic   clear_q;
    logic   clear_d;
    logic [PW-1:0] presc_q;

`ifdef LAP_HOLD_EN
    logic hold_q;
    logic hold_d;
`endif

    // Next-state decode; clear beats stop beats start (beats lap)
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
`ifdef LAP_HOLD_EN
        hold_d  = hold_q;
`endif
        if (press[B_CLEAR]) begin
            state_d = IDLE;
            clear_d = 1'b1;
`ifdef LAP_HOLD_EN
            hold_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[B_STOP]) begin
                        state_d = IDLE;
                    end else if (press[B_START]) begin
                        state_d = RUNNING;
                    end
                end
                RUNNING: begin
                    if (press[B_STOP]) begin
                        state_d = PAUSED;
                    end else if (press[B_START]) begin
                        state_d = RUNNING;
`ifdef LAP_HOLD_EN
                    end else if (press[B_LAP]) begin
                        hold_d = ~hold_q;
`endif
                    end
                end
                PAUSED: begin
                    if (press[B_STOP]) begin
                        state_d = PAUSED;
                    end else if (press[B_START]) begin
                        state_d = RUNNING;
`ifdef LAP_HOLD_EN
                    end else if (press[B_LAP]) begin
                        hold_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered clear pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

`ifdef LAP_HOLD_EN
    // Display-freeze flag driven by lap presses
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;
`endif

    // Free-running prescaler, realigned by a clear press
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (press[B_CLEAR] || presc_q == P_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick_ms     = (presc_q == P_LAST);
    assign run         = (state_q == RUNNING);
    assign state       = state_q;
    assign count_en    = tick_ms & run;
    assign clear_pulse = clear_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Expected outputs are queued per cycle and compared when the DUT responds.
module tb_stopwatch_ctrl;

    localparam int TD = 5;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PAU  = 2'b10;

    typedef struct {
        logic [1:0] st;
        logic       run;
        logic       tick;
        logic       cen;
        logic       clr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       run;
    logic [1:0] state;
    logic       tick_ms;
    logic       count_en;
    logic       clear_pulse;
`ifdef LAP_HOLD_EN
    logic       btn_lap = 1'b0;
    logic       hold;
`endif

    exp_t sb[$];
    int   p = 0;
    int   total = 0;
    int   passed = 0;

    stopwatch_ctrl #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_clear(btn_clear),
`ifdef LAP_HOLD_EN
        .btn_lap(btn_lap),
        .hold(hold),
`endif
        .run(run),
        .state(state),
        .tick_ms(tick_ms),
        .count_en(count_en),
        .clear_pulse(clear_pulse)
    );

    always #5 clk = ~clk;

    // Predict the outputs after the coming edge and queue them
    task automatic push_exp(input logic [1:0] es, input bit clr);
        exp_t e;
        p = (reset || clr) ? 0 : (p + 1) % TD;
        e.st   = es;
        e.run  = (es == S_RUN);
        e.tick = (p == TD - 1);
        e.cen  = e.tick && e.run;
        e.clr  = clr;
        sb.push_back(e);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    function automatic string got_str();
        return $sformatf("st=%b run=%b tick=%b cen=%b clr=%b",
                         state, run, tick_ms, count_en, clear_pulse);
    endfunction

    function automatic string exp_str(input exp_t e);
        return $sformatf("st=%b run=%b tick=%b cen=%b clr=%b",
                         e.st, e.run, e.tick, e.cen, e.clr);
    endfunction

    task automatic test_reset();
        exp_t e;
        int ticks = 0;
        for (int i = 0; i < 23; i++) begin
            reset = (i < 3);
            push_exp(S_IDLE, 1'b0);
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL reset cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
            if (tick_ms === 1'b1) ticks++;
        end
        total++;
        if (ticks !== 4)
            $display("FAIL reset_tick_count: got %0d required 4", ticks);
        else
            passed++;
    endtask

    task automatic test_glitch();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            btn_start = (i < 3);
            push_exp(S_IDLE, 1'b0);
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL glitch cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
        end
    endtask

    task automatic test_start_run();
        exp_t e;
        int cen_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            btn_start = (i < 8);
            push_exp((i >= 6) ? S_RUN : S_IDLE, 1'b0);
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL start cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
            if (i >= 7 && count_en === 1'b1) cen_cnt++;
        end
        total++;
        if (cen_cnt !== 5)
            $display("FAIL run_25_cycles: got %0d count_en pulses required 5", cen_cnt);
        else
            passed++;
    endtask

    task automatic test_pause_resume();
        exp_t e;
        logic [1:0] es;
        for (int i = 0; i < 40; i++) begin
            btn_stop  = (i < 8);
            btn_start = (i >= 20 && i < 28);
            es = (i < 6) ? S_RUN : (i < 26) ? S_PAU : S_RUN;
            push_exp(es, 1'b0);
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL pause cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
        end
    endtask

    task automatic test_clear_priority();
        exp_t e;
        logic [1:0] es;
        int clr_cnt = 0;
        for (int i = 0; i < 46; i++) begin
            btn_stop  = (i < 8);
            btn_start = (i >= 16 && i < 24);
            btn_clear = (i >= 16 && i < 24) || (i >= 32 && i < 40);
            es = (i < 6) ? S_RUN : (i < 22) ? S_PAU : S_IDLE;
            push_exp(es, (i == 22 || i == 38));
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL clear cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
            if (clear_pulse === 1'b1) clr_cnt++;
        end
        total++;
        if (clr_cnt !== 2)
            $display("FAIL clear_pulse_count: got %0d required 2", clr_cnt);
        else
            passed++;
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        logic [1:0] es;
        for (int i = 0; i < 51; i++) begin
            btn_start = (i < 8) || (i >= 32 && i < 46);
            btn_stop  = (i >= 12 && i < 28);
            reset     = (i == 14 || i == 15 || i == 34 || i == 35);
            es = (i < 6) ? S_IDLE : (i < 14) ? S_RUN : (i < 42) ? S_IDLE : S_RUN;
            push_exp(es, 1'b0);
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL midreset cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
        end
        reset = 1'b0;
    endtask

`ifdef LAP_HOLD_EN
    task automatic test_lap();
        exp_t e;
        logic [1:0] es;
        logic eh;
        for (int i = 0; i < 97; i++) begin
            btn_lap   = (i < 8) || (i >= 16 && i < 24) ||
                        (i >= 44 && i < 52) || (i >= 70 && i < 78);
            btn_clear = (i >= 30 && i < 38) || (i >= 84 && i < 92);
            btn_start = (i >= 56 && i < 64);
            es = (i < 36) ? S_RUN : (i < 62) ? S_IDLE : (i < 90) ? S_RUN : S_IDLE;
            eh = (i >= 6 && i < 22) || (i >= 76 && i < 90);
            push_exp(es, (i == 36 || i == 90));
            edge_wait();
            e = sb.pop_front();
            total++;
            if ({state, run, tick_ms, count_en, clear_pulse} !==
                {e.st, e.run, e.tick, e.cen, e.clr})
                $display("FAIL lap cyc %0d: got %s required %s", i, got_str(), exp_str(e));
            else
                passed++;
            total++;
            if (hold !== eh)
                $display("FAIL hold cyc %0d: got %b required %b", i, hold, eh);
            else
                passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_start_run();
        test_pause_resume();
        test_clear_priority();
        test_reset_midrun();
`ifdef LAP_HOLD_EN
        test_lap();
`endif
        total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
